// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, iterative multiplier and EX/MEM register
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Rs_data_in,
   input  logic [31:0] Rt_data_in,
   input  logic [31:0] Imm_in,
   input  logic [1:0]  ALU_op_in,
   input  logic [4:0]  Rs_addr_in,
   input  logic [4:0]  Rt_addr_in,
   input  logic [4:0]  Rd_addr_in,
   input  logic        ALU_src_in,
   input  logic        Reg_dst_in,
   input  logic        Reg_w_in,
   input  logic        Mem_w_in,
   input  logic        Mem_r_in,
   input  logic        Mem_to_reg_in,
   input  logic        Wb_w_in,
   input  logic [4:0]  Wb_addr_in,
   input  logic [31:0] Wb_data_in,
   output logic [31:0] Alu_result_out,
   output logic [31:0] Store_data_out,
   output logic [4:0]  Wr_addr_out,
   output logic        Reg_w_out,
   output logic        Mem_w_out,
   output logic        Mem_r_out,
   output logic        Mem_to_reg_out,
   output logic        Stall_out
);

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_MULT = 6'b011000;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t      state, next_state;
   logic [31:0] fwd_a, fwd_b, op_b, alu_res;
   logic [4:0]  wr_addr_sel;
   logic        is_mult;

   // multiplier working registers
   logic [31:0] mcand, mplier, acc, acc_step;
   logic [4:0]  cnt;
   logic [4:0]  lat_wr_addr;
   logic        lat_reg_w, lat_mem_w, lat_mem_r, lat_mem_to_reg;

   // EX/MEM wins over MEM/WB; r0 and loads still in EX/MEM are never forwarded
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  addr,
      input logic [31:0] raw,
      input logic        exm_w,
      input logic        exm_r,
      input logic [4:0]  exm_addr,
      input logic [31:0] exm_data,
      input logic        wb_w,
      input logic [4:0]  wb_addr,
      input logic [31:0] wb_data
   );
      if (exm_w && !exm_r && (exm_addr != 5'd0) && (exm_addr == addr))
         return exm_data;
      else if (wb_w && (wb_addr != 5'd0) && (wb_addr == addr))
         return wb_data;
      else
         return raw;
   endfunction

   // operand selection with forwarding
   always_comb begin
      fwd_a = fwd_sel(Rs_addr_in, Rs_data_in, Reg_w_out, Mem_r_out, Wr_addr_out,
                      Alu_result_out, Wb_w_in, Wb_addr_in, Wb_data_in);
      fwd_b = fwd_sel(Rt_addr_in, Rt_data_in, Reg_w_out, Mem_r_out, Wr_addr_out,
                      Alu_result_out, Wb_w_in, Wb_addr_in, Wb_data_in);
      op_b        = ALU_src_in ? Imm_in : fwd_b;
      wr_addr_sel = Reg_dst_in ? Rd_addr_in : Rt_addr_in;
      is_mult     = (ALU_op_in == 2'b10) && (Imm_in[5:0] == FN_MULT);
   end

   // single-cycle ALU; unknown functs and mult produce 0 here
   always_comb begin
      alu_res = 32'd0;
      case (ALU_op_in)
         2'b00: alu_res = fwd_a + op_b;
         2'b01: alu_res = fwd_a - op_b;
         2'b11: alu_res = fwd_a | op_b;
         default: begin
            case (Imm_in[5:0])
               FN_ADD:  alu_res = fwd_a + op_b;
               FN_SUB:  alu_res = fwd_a - op_b;
               FN_AND:  alu_res = fwd_a & op_b;
               FN_OR:   alu_res = fwd_a | op_b;
               FN_SLT:  alu_res = {31'd0, ($signed(fwd_a) < $signed(op_b))};
               default: alu_res = 32'd0;
            endcase
         end
      endcase
   end

   // one shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_step = acc + (mplier[0] ? mcand : 32'd0);
   end

   // multiplier state register
   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // multiplier next state: 32 steps after capture, then back to idle
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (is_mult) next_state = S_MUL;
         S_MUL:  if (cnt == 5'd31) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // EX/MEM register and multiplier datapath
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         Alu_result_out <= 32'd0;
         Store_data_out <= 32'd0;
         Wr_addr_out    <= 5'd0;
         Reg_w_out      <= 1'b0;
         Mem_w_out      <= 1'b0;
         Mem_r_out      <= 1'b0;
         Mem_to_reg_out <= 1'b0;
         Stall_out      <= 1'b0;
         mcand          <= 32'd0;
         mplier         <= 32'd0;
         acc            <= 32'd0;
         cnt            <= 5'd0;
         lat_wr_addr    <= 5'd0;
         lat_reg_w      <= 1'b0;
         lat_mem_w      <= 1'b0;
         lat_mem_r      <= 1'b0;
         lat_mem_to_reg <= 1'b0;
      end else if (state == S_IDLE) begin
         if (is_mult) begin
            // capture operands now so later forwarding changes cannot disturb the product
            mcand          <= fwd_a;
            mplier         <= op_b;
            acc            <= 32'd0;
            cnt            <= 5'd0;
            lat_wr_addr    <= wr_addr_sel;
            lat_reg_w      <= Reg_w_in;
            lat_mem_w      <= Mem_w_in;
            lat_mem_r      <= Mem_r_in;
            lat_mem_to_reg <= Mem_to_reg_in;
            Stall_out      <= 1'b1;
            Reg_w_out      <= 1'b0;
            Mem_w_out      <= 1'b0;
            Mem_r_out      <= 1'b0;
            Mem_to_reg_out <= 1'b0;
         end else begin
            Alu_result_out <= alu_res;
            Store_data_out <= fwd_b;
            Wr_addr_out    <= wr_addr_sel;
            Reg_w_out      <= Reg_w_in;
            Mem_w_out      <= Mem_w_in;
            Mem_r_out      <= Mem_r_in;
            Mem_to_reg_out <= Mem_to_reg_in;
         end
      end else begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
         if (cnt == 5'd31) begin
            Alu_result_out <= acc_step;
            Wr_addr_out    <= lat_wr_addr;
            Reg_w_out      <= lat_reg_w;
            Mem_w_out      <= lat_mem_w;
            Mem_r_out      <= lat_mem_r;
            Mem_to_reg_out <= lat_mem_to_reg;
            Stall_out      <= 1'b0;
         end else begin
            Reg_w_out      <= 1'b0;
            Mem_w_out      <= 1'b0;
            Mem_r_out      <= 1'b0;
            Mem_to_reg_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

   logic        clk = 1'b1;
   logic        rst;
   logic [31:0] Rs_data_in, Rt_data_in, Imm_in, Wb_data_in;
   logic [1:0]  ALU_op_in;
   logic [4:0]  Rs_addr_in, Rt_addr_in, Rd_addr_in, Wb_addr_in;
   logic        ALU_src_in, Reg_dst_in, Reg_w_in, Mem_w_in, Mem_r_in, Mem_to_reg_in, Wb_w_in;
   logic [31:0] Alu_result_out, Store_data_out;
   logic [4:0]  Wr_addr_out;
   logic        Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out, Stall_out;
   logic [3:0]  ctrl;

   int tests = 0;
   int errors = 0;
   int cycles;
   logic bub, held, bad;

   assign ctrl = {Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out};

   ex_stage dut (
      .clk(clk), .rst(rst),
      .Rs_data_in(Rs_data_in), .Rt_data_in(Rt_data_in), .Imm_in(Imm_in),
      .ALU_op_in(ALU_op_in), .Rs_addr_in(Rs_addr_in), .Rt_addr_in(Rt_addr_in),
      .Rd_addr_in(Rd_addr_in), .ALU_src_in(ALU_src_in), .Reg_dst_in(Reg_dst_in),
      .Reg_w_in(Reg_w_in), .Mem_w_in(Mem_w_in), .Mem_r_in(Mem_r_in),
      .Mem_to_reg_in(Mem_to_reg_in), .Wb_w_in(Wb_w_in), .Wb_addr_in(Wb_addr_in),
      .Wb_data_in(Wb_data_in), .Alu_result_out(Alu_result_out),
      .Store_data_out(Store_data_out), .Wr_addr_out(Wr_addr_out),
      .Reg_w_out(Reg_w_out), .Mem_w_out(Mem_w_out), .Mem_r_out(Mem_r_out),
      .Mem_to_reg_out(Mem_to_reg_out), .Stall_out(Stall_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clr;
      Rs_data_in = 0; Rt_data_in = 0; Imm_in = 0; ALU_op_in = 0;
      Rs_addr_in = 0; Rt_addr_in = 0; Rd_addr_in = 0;
      ALU_src_in = 0; Reg_dst_in = 1; Reg_w_in = 0; Mem_w_in = 0; Mem_r_in = 0;
      Mem_to_reg_in = 0; Wb_w_in = 0; Wb_addr_in = 0; Wb_data_in = 0;
   endtask

   // runs a captured mult to completion, counting stall cycles from the capture edge
   task automatic run_mul(input logic [31:0] hold_val);
      cycles = 1; bub = 0; held = 1;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (!Stall_out) break;
         cycles++;
         if (ctrl != 4'd0) bub = 1;
         if (Alu_result_out != hold_val) held = 0;
      end
   endtask

   initial begin
      clr;
      rst = 1;
      Rs_data_in = 5; Rt_data_in = 7; Rs_addr_in = 1; Rt_addr_in = 2; Rd_addr_in = 3;
      Reg_w_in = 1; Mem_w_in = 1; Mem_r_in = 1; Mem_to_reg_in = 1;
      Wb_w_in = 1; Wb_addr_in = 1; Wb_data_in = 32'h55;
      tick; tick;
      check("rst_alu", Alu_result_out, 0);
      check("rst_store", Store_data_out, 0);
      check("rst_wr", Wr_addr_out, 0);
      check("rst_ctrl", ctrl, 0);
      check("rst_stall", Stall_out, 0);

      Wb_w_in = 0; Mem_w_in = 0; Mem_r_in = 0; Mem_to_reg_in = 0;
      rst = 0;
      tick;
      check("post_rst_add", Alu_result_out, 12);
      check("post_rst_store", Store_data_out, 7);
      check("post_rst_wr", Wr_addr_out, 3);
      check("post_rst_regw", Reg_w_out, 1);

      // EX/MEM forwarding with priority over MEM/WB
      Rs_data_in = 8; Rt_data_in = 8;
      tick;
      check("add_r3", Alu_result_out, 32'h10);
      ALU_op_in = 2'b01; Rs_addr_in = 3; Rs_data_in = 32'h55; Rt_addr_in = 4; Rt_data_in = 4;
      Wb_w_in = 1; Wb_addr_in = 3; Wb_data_in = 32'h99; Rd_addr_in = 6;
      tick;
      check("fwd_exmem_prio", Alu_result_out, 32'h0C);
      check("fwd_wr6", Wr_addr_out, 6);
      ALU_op_in = 2'b00; Rt_data_in = 1; Rd_addr_in = 7;
      tick;
      check("fwd_memwb", Alu_result_out, 32'h9A);

      // register 0 never forwarded
      Wb_w_in = 0; Rs_addr_in = 1; Rs_data_in = 1; Rt_addr_in = 2; Rt_data_in = 2; Rd_addr_in = 0;
      tick;
      check("write_r0", Alu_result_out, 3);
      Rs_addr_in = 0; Rs_data_in = 32'h40; Rt_addr_in = 0; Rt_data_in = 5;
      Wb_w_in = 1; Wb_addr_in = 0; Wb_data_in = 32'h77; Rd_addr_in = 8;
      tick;
      check("r0_alu", Alu_result_out, 32'h45);
      check("r0_store", Store_data_out, 5);

      // load in EX/MEM is skipped, MEM/WB used instead
      Wb_w_in = 0; Rs_addr_in = 1; Rs_data_in = 32'h100; Rt_addr_in = 2; Rt_data_in = 4;
      Rd_addr_in = 5; Mem_r_in = 1; Mem_to_reg_in = 1;
      tick;
      check("load_alu", Alu_result_out, 32'h104);
      check("load_memr", Mem_r_out, 1);
      Mem_r_in = 0; Mem_to_reg_in = 0; Reg_w_in = 0;
      Rs_addr_in = 5; Rs_data_in = 0; Rt_addr_in = 5; Rt_data_in = 0; ALU_src_in = 1; Imm_in = 0;
      Wb_w_in = 1; Wb_addr_in = 5; Wb_data_in = 32'h22; Rd_addr_in = 9;
      tick;
      check("load_skip_a", Alu_result_out, 32'h22);
      check("load_skip_b", Store_data_out, 32'h22);

      // funct decoding, slt, immediate
      Wb_w_in = 0; ALU_src_in = 0; Reg_w_in = 1; Rs_addr_in = 10; Rt_addr_in = 11; Rd_addr_in = 12;
      ALU_op_in = 2'b10; Imm_in = 32'h2A; Rs_data_in = 32'hFFFF_FFFF; Rt_data_in = 1;
      tick;
      check("slt_neg", Alu_result_out, 1);
      Rs_data_in = 1; Rt_data_in = 32'hFFFF_FFFF;
      tick;
      check("slt_pos", Alu_result_out, 0);
      Imm_in = 32'h24; Rs_data_in = 32'hFF00_FF00; Rt_data_in = 32'h0FF0_0FF0;
      tick;
      check("and", Alu_result_out, 32'h0F00_0F00);
      Imm_in = 32'h3F;
      tick;
      check("bad_funct", Alu_result_out, 0);
      ALU_op_in = 2'b01; Rs_data_in = 0; Rt_data_in = 1;
      tick;
      check("sub_wrap", Alu_result_out, 32'hFFFF_FFFF);
      ALU_op_in = 2'b11; ALU_src_in = 1; Rs_data_in = 32'hF0; Imm_in = 32'h0F;
      Reg_dst_in = 0; Rt_addr_in = 9; Rt_data_in = 32'h33; Rd_addr_in = 17;
      tick;
      check("or_imm", Alu_result_out, 32'hFF);
      check("regdst0_wr", Wr_addr_out, 9);
      check("or_store", Store_data_out, 32'h33);

      // multiply
      Reg_dst_in = 1; Rd_addr_in = 7; Rs_addr_in = 12; Rt_addr_in = 13; ALU_src_in = 0;
      ALU_op_in = 2'b10; Imm_in = 32'h18; Rs_data_in = 32'h0001_0003; Rt_data_in = 32'h0002_0005;
      tick;
      check("mul_stall_e0", Stall_out, 1);
      check("mul_bubble_e0", ctrl, 0);
      ALU_op_in = 2'b00; Rs_data_in = 32'h1234; Mem_w_in = 1; Rd_addr_in = 20;
      Wb_w_in = 1; Wb_addr_in = 12; Wb_data_in = 32'hDEAD;
      run_mul(32'hFF);
      check("mul_cycles", cycles, 32);
      check("mul_bubbles", bub, 0);
      check("mul_alu_held", held, 1);
      check("mul_product", Alu_result_out, 32'h000B_000F);
      check("mul_regw", Reg_w_out, 1);
      check("mul_wr", Wr_addr_out, 7);
      check("mul_memw", Mem_w_out, 0);

      // zero operand still takes the full latency
      Mem_w_in = 0; Wb_w_in = 0; ALU_op_in = 2'b10; Imm_in = 32'h18;
      Rs_data_in = 0; Rt_data_in = 5; Rd_addr_in = 8;
      tick;
      run_mul(32'h000B_000F);
      check("mul0_cycles", cycles, 32);
      check("mul0_product", Alu_result_out, 0);

      // reset aborts a multiply in flight
      Rs_data_in = 3; Rt_data_in = 4; Rd_addr_in = 9;
      tick;
      for (int i = 0; i < 9; i++) tick;
      check("abort_pre_stall", Stall_out, 1);
      #2 rst = 1;
      #1;
      check("abort_stall", Stall_out, 0);
      check("abort_alu", Alu_result_out, 0);
      check("abort_ctrl", ctrl, 0);
      tick;
      clr;
      Rs_addr_in = 1; Rt_addr_in = 2; Rs_data_in = 1; Rt_data_in = 1;
      rst = 0;
      tick;
      check("abort_first_op", Alu_result_out, 2);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (Alu_result_out != 2 || Stall_out || Reg_w_out) bad = 1;
      end
      check("abort_no_product", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
  clk  in  1  single clock; all state updates on the falling edge, matching the pipeline registers.
  rst  in  1  asynchronous, active-high reset.
  Rs_data_in, Rt_data_in  in  32 each  register operands from the ID/EX register.
  Imm_in  in  32  sign-extended immediate; bits [5:0] are the funct field.
  ALU_op_in  in  2  decoded ALU class.
  Rs_addr_in, Rt_addr_in, Rd_addr_in  in  5 each  source and destination register numbers.
  ALU_src_in, Reg_dst_in  in  1 each  operand-B select and destination select.
  Reg_w_in, Mem_w_in, Mem_r_in, Mem_to_reg_in  in  1 each  control bits passed to EX/MEM.
  Wb_w_in  in  1  MEM/WB write enable, for forwarding.
  Wb_addr_in  in  5  MEM/WB destination register.
  Wb_data_in  in  32  MEM/WB write-back value.
  Alu_result_out  out  32  EX/MEM ALU result.
  Store_data_out  out  32  EX/MEM store data (forwarded Rt).
  Wr_addr_out  out  5  EX/MEM destination register.
  Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out  out  1 each  EX/MEM control bits.
  Stall_out  out  1  registered busy flag; upstream holds ID/EX and IF/ID while it is high.

Function
REQ-002 Forwarding for operand A (Rs) SHALL use a fixed priority:
  - EX/MEM: taken when Reg_w_out=1, Mem_r_out=0, Wr_addr_out!=0 and Wr_addr_out==Rs_addr_in; value is Alu_result_out.
  - MEM/WB: otherwise taken when Wb_w_in=1, Wb_addr_in!=0 and Wb_addr_in==Rs_addr_in; value is Wb_data_in.
  - Otherwise the value is Rs_data_in.
REQ-003 Forwarded Rt SHALL use the same rule as REQ-002 with Rt_addr_in and Rt_data_in.
REQ-004 Register 0 SHALL never be forwarded.
REQ-005 A load sitting in EX/MEM SHALL NOT be forwarded; load-use stalls are upstream's responsibility.
REQ-006 Operand B SHALL be Imm_in when ALU_src_in=1, and forwarded Rt otherwise.
REQ-007 ALU operation SHALL be selected as follows:
  - ALU_op 00: add.
  - ALU_op 01: subtract.
  - ALU_op 11: bitwise OR.
  - ALU_op 10: by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0), 011000 mult.
  - ALU_op 10 with any other funct: result 0.
REQ-008 Add and subtract SHALL be modulo 2^32 with no overflow detection.
REQ-009 Single-cycle operations SHALL be registered on the falling edge while Stall_out=0. Registered values:
  - Alu_result_out = the ALU result.
  - Store_data_out = forwarded Rt.
  - Wr_addr_out = Rd_addr_in when Reg_dst_in=1, else Rt_addr_in.
  - The four control outputs = their inputs.
  - Latency: 1 edge.
REQ-010 The multiplier FSM SHALL have two states, IDLE and MUL.
REQ-011 In IDLE, a falling edge that captures mult SHALL:
  - latch both operands, the destination and the control bits;
  - clear a 5-bit counter and a 32-bit accumulator;
  - set Stall_out=1 and enter MUL;
  - drive a bubble on EX/MEM (all four control outputs 0, data outputs unchanged).
REQ-012 In MUL, each falling edge SHALL perform one shift-add step (low 32 bits only) and increment the counter.
REQ-013 The edge on which the counter equals 31 SHALL:
  - write the product's low 32 bits to Alu_result_out, with the latched destination and control bits;
  - clear Stall_out and return to IDLE.
  Stall_out is therefore high for exactly 32 cycles (capture edge E0 through edge E32, result written at E32).
REQ-014 While in MUL, all ID/EX inputs SHALL be ignored.
REQ-015 While in MUL, EX/MEM SHALL present a bubble on every edge except the completion edge.
REQ-016 Operands SHALL be latched at capture, so forwarding sources changing during MUL have no effect.
REQ-017 A mult with either operand 0 SHALL still take the full 32 cycles.

Reset
REQ-018 While rst=1, the block SHALL hold its outputs and state at:
  - all data outputs 0;
  - Wr_addr_out 0;
  - all control outputs 0;
  - Stall_out 0;
  - FSM in IDLE, counter and accumulator 0.
  Reset takes effect immediately, independent of clk.
REQ-019 Reset asserted during MUL SHALL abort the multiply with no result written.
REQ-020 After rst deasserts, the first falling edge SHALL process the ID/EX inputs normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Reset: drive nonzero inputs with rst=1 -> every output is 0; the first falling edge after release registers add 5+7 -> Alu_result_out=12.
  - EX/MEM forwarding: a previous add writes r3=0x10, the next op is sub Rs=r3, Rt_data=4 -> Alu_result_out=0x0C. With Wb_addr_in=3 and Wb_data_in=0x99 applied at the same time -> still 0x0C (EX/MEM has priority).
  - Register 0 and loads: r0 targeted by both forwarding paths -> raw Rs_data_in is used. A load (Mem_r_out=1) in EX/MEM to r5 with Wb path r5=0x22 -> operand 0x22.
  - slt and immediate: slt with operands -1 and 1 -> 1. ALU_op 11 with ALU_src=1, Rs=0xF0, Imm=0x0F -> 0xFF. Reg_dst=0 -> Wr_addr_out equals Rt_addr_in.
  - Multiply: 0x0001_0003 x 0x0002_0005 -> Stall_out high for exactly 32 cycles, control outputs 0 throughout, then Alu_result_out=0x000B_000F with Reg_w_out=1. rst pulsed at cycle 10 of a second mult -> Stall_out=0 and outputs 0 immediately, and no product is ever written.
